buzz_sequencer: RTL and testbench

BUZZ_SEQUENCER -- requirements
Module: buzz_sequencer

---
 rtl/buzz_seq_pkg.sv | 36 +++
 rtl/buzz_phase_timer.sv | 37 +++
 rtl/buzz_sequencer.sv | 166 ++++++++++++++++
 tb/tb_buzz_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/buzz_seq_pkg.sv
// Buzzer sequencer shared types.
// State encoding, source codes and chime clamp.
package buzz_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CHIME_ON  = 3'd1,
    S_CHIME_OFF = 3'd2,
    S_ALARM_ON  = 3'd3,
    S_ALARM_OFF = 3'd4,
    S_SNOOZE    = 3'd5
  } state_t;

  localparam logic [1:0] SRC_IDLE   = 2'b00;
  localparam logic [1:0] SRC_CHIME  = 2'b01;
  localparam logic [1:0] SRC_ALARM  = 2'b10;
  localparam logic [1:0] SRC_SNOOZE = 2'b11;

  localparam int CHIME_MAX = 12;

  function automatic logic [1:0] src_of(input state_t s);
    logic [1:0] r;
    case (s)
      S_CHIME_ON, S_CHIME_OFF: r = SRC_CHIME;
      S_ALARM_ON, S_ALARM_OFF: r = SRC_ALARM;
      S_SNOOZE:                r = SRC_SNOOZE;
      default:                 r = SRC_IDLE;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] clamp_chime(input logic [3:0] n);
    return (n > 4'(CHIME_MAX)) ? 4'(CHIME_MAX) : n;
  endfunction

endpackage

// File: rtl/buzz_phase_timer.sv
// ON/OFF phase timer: restarts at zero on load,
// holds at the terminal count, done while there.
module buzz_phase_timer #(
  parameter int CW = 24
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          load,
  input  logic [CW-1:0] tc,
  output logic          done
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Count up from zero, saturate at terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (cnt_q != tc) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == tc);

endmodule

// File: rtl/buzz_sequencer.sv
// Buzzer sequencer: hourly chime, alarm with
// snooze, stop key and beep-exhaustion timeout.
module buzz_sequencer
  import buzz_seq_pkg::*;
#(
  parameter int ON_CYC      = 12500000,
  parameter int OFF_CYC     = 12500000,
  parameter int ALARM_BEEPS = 120,
  parameter int SNOOZE_SEC  = 300,
  parameter int SNOOZE_MAX  = 3,
  parameter int CW          = 24
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tick_1hz,
  input  logic       alarm_req,
  input  logic       chime_req,
  input  logic [3:0] chime_count,
  input  logic       stop,
  input  logic       snooze,
  output logic       buzz_en,
  output logic [1:0] src,
  output logic       timeout
);

  localparam int BW = $clog2(ALARM_BEEPS + CHIME_MAX + 1);
  localparam int SW = $clog2(SNOOZE_SEC + 2);
  localparam int NW = $clog2(SNOOZE_MAX + 2);

  localparam logic [BW-1:0] BEEP_N = BW'(ALARM_BEEPS);
  localparam logic [SW-1:0] SEC_N  = SW'(SNOOZE_SEC);
  localparam logic [NW-1:0] SNZ_N  = NW'(SNOOZE_MAX);
  localparam logic [CW-1:0] ON_TC  = CW'(ON_CYC - 1);
  localparam logic [CW-1:0] OFF_TC = CW'(OFF_CYC - 1);

  state_t        state_q, state_d;
  logic [BW-1:0] beep_q, beep_d, beep_inc;
  logic [SW-1:0] sec_q, sec_d;
  logic [NW-1:0] snz_q, snz_d;
  logic [3:0]    chn_q, chn_d;
  logic          buzz_q, to_q, to_d;
  logic [1:0]    src_q;
  logic          busy, alarm_ok, in_alarm, is_off;
  logic          ph_load, ph_tc_hit;
  logic [CW-1:0] ph_tc;

  assign busy     = (state_q != S_IDLE);
  assign in_alarm = (state_q == S_ALARM_ON) ||
                    (state_q == S_ALARM_OFF);
  assign alarm_ok = !in_alarm;
  assign is_off   = (state_q == S_CHIME_OFF) ||
                    (state_q == S_ALARM_OFF);
  assign ph_tc    = is_off ? OFF_TC : ON_TC;
  assign ph_load  = (state_d != state_q);
  assign beep_inc = beep_q + BW'(1);

  buzz_phase_timer #(.CW(CW)) u_timer (
    .clk  (clk),
    .rstn (rstn),
    .load (ph_load),
    .tc   (ph_tc),
    .done (ph_tc_hit)
  );

  // Next-state and counter updates, key priority first.
  always_comb begin
    state_d = state_q;
    beep_d  = beep_q;
    sec_d   = sec_q;
    snz_d   = snz_q;
    chn_d   = chn_q;
    to_d    = 1'b0;
    priority case (1'b1)
      (stop && busy): begin
        state_d = S_IDLE;
        beep_d  = '0;
        sec_d   = '0;
        snz_d   = '0;
      end
      (alarm_req && alarm_ok): begin
        state_d = S_ALARM_ON;
        beep_d  = '0;
        sec_d   = '0;
      end
      (snooze && in_alarm && (snz_q < SNZ_N)): begin
        state_d = S_SNOOZE;
        snz_d   = snz_q + NW'(1);
        sec_d   = '0;
      end
      (chime_req && !busy && (chime_count != 4'd0)): begin
        state_d = S_CHIME_ON;
        beep_d  = '0;
        chn_d   = clamp_chime(chime_count);
      end
      default: begin
        unique case (state_q)
          S_CHIME_ON: if (ph_tc_hit) begin
            if (beep_inc == BW'(chn_q)) begin
              state_d = S_IDLE;
              beep_d  = '0;
            end else begin
              state_d = S_CHIME_OFF;
              beep_d  = beep_inc;
            end
          end
          S_CHIME_OFF: if (ph_tc_hit) begin
            state_d = S_CHIME_ON;
          end
          S_ALARM_ON: if (ph_tc_hit) begin
            if (beep_inc == BEEP_N) begin
              state_d = S_IDLE;
              beep_d  = '0;
              snz_d   = '0;
              to_d    = 1'b1;
            end else begin
              state_d = S_ALARM_OFF;
              beep_d  = beep_inc;
            end
          end
          S_ALARM_OFF: if (ph_tc_hit) begin
            state_d = S_ALARM_ON;
          end
          S_SNOOZE: if (tick_1hz) begin
            if (sec_q + SW'(1) == SEC_N) begin
              state_d = S_ALARM_ON;
              beep_d  = '0;
              sec_d   = '0;
            end else begin
              sec_d = sec_q + SW'(1);
            end
          end
          default: ;
        endcase
      end
    endcase
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      beep_q  <= '0;
      sec_q   <= '0;
      snz_q   <= '0;
      chn_q   <= '0;
      buzz_q  <= 1'b0;
      src_q   <= SRC_IDLE;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      beep_q  <= beep_d;
      sec_q   <= sec_d;
      snz_q   <= snz_d;
      chn_q   <= chn_d;
      buzz_q  <= (state_d == S_CHIME_ON) ||
                 (state_d == S_ALARM_ON);
      src_q   <= src_of(state_d);
      to_q    <= to_d;
    end
  end

  assign buzz_en = buzz_q;
  assign src     = src_q;
  assign timeout = to_q;

endmodule

// File: tb/tb_buzz_sequencer.sv
// Directed bench for buzz_sequencer with short
// phase lengths and hand-computed beep patterns.
module tb_buzz_sequencer;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       alarm_req = 1'b0;
  logic       chime_req = 1'b0;
  logic [3:0] chime_count = 4'd0;
  logic       stop = 1'b0;
  logic       snooze = 1'b0;
  logic       buzz_en;
  logic [1:0] src;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  buzz_sequencer #(
    .ON_CYC      (4),
    .OFF_CYC     (3),
    .ALARM_BEEPS (3),
    .SNOOZE_SEC  (2),
    .SNOOZE_MAX  (1),
    .CW          (4)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .tick_1hz    (tick_1hz),
    .alarm_req   (alarm_req),
    .chime_req   (chime_req),
    .chime_count (chime_count),
    .stop        (stop),
    .snooze      (snooze),
    .buzz_en     (buzz_en),
    .src         (src),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [1:0] obs,
                     input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag,
                         input logic b,
                         input logic [1:0] s,
                         input logic t);
    chk({tag, "_buzz"}, {1'b0, buzz_en}, {1'b0, b});
    chk({tag, "_src"}, src, s);
    chk({tag, "_timeout"}, {1'b0, timeout}, {1'b0, t});
  endtask

  task automatic run(input string tag,
                     input logic b,
                     input logic [1:0] s,
                     input int n);
    for (int i = 0; i < n; i++) begin
      chk_out(tag, b, s, 1'b0);
      step();
    end
  endtask

  task automatic alarm_beeps(input string tag);
    run(tag, 1'b1, 2'b10, 4);
    run(tag, 1'b0, 2'b10, 3);
    run(tag, 1'b1, 2'b10, 4);
    run(tag, 1'b0, 2'b10, 3);
    run(tag, 1'b1, 2'b10, 4);
    chk_out({tag, "_end"}, 1'b0, 2'b00, 1'b1);
    step();
    chk_out({tag, "_after"}, 1'b0, 2'b00, 1'b0);
  endtask

  initial begin
    step();
    step();
    chk_out("reset", 1'b0, 2'b00, 1'b0);
    rstn = 1'b1;
    step();

    // chime of 3 beeps
    chime_count = 4'd3;
    chime_req = 1'b1;
    step();
    chime_req = 1'b0;
    run("ch3", 1'b1, 2'b01, 4);
    run("ch3", 1'b0, 2'b01, 3);
    run("ch3", 1'b1, 2'b01, 4);
    run("ch3", 1'b0, 2'b01, 3);
    run("ch3", 1'b1, 2'b01, 4);
    chk_out("ch3_end", 1'b0, 2'b00, 1'b0);
    step();

    // chime count 15 clamps to 12 beeps
    chime_count = 4'd15;
    chime_req = 1'b1;
    step();
    chime_req = 1'b0;
    for (int k = 0; k < 11; k++) begin
      run("ch15", 1'b1, 2'b01, 4);
      run("ch15", 1'b0, 2'b01, 3);
    end
    run("ch15", 1'b1, 2'b01, 4);
    chk_out("ch15_end", 1'b0, 2'b00, 1'b0);
    step();

    // chime count 0 ignored
    chime_count = 4'd0;
    chime_req = 1'b1;
    step();
    chime_req = 1'b0;
    run("ch0", 1'b0, 2'b00, 5);

    // unattended alarm times out
    alarm_req = 1'b1;
    step();
    alarm_req = 1'b0;
    alarm_beeps("al");

    // snooze during beep 2, second snooze ignored
    alarm_req = 1'b1;
    step();
    alarm_req = 1'b0;
    run("sz", 1'b1, 2'b10, 4);
    run("sz", 1'b0, 2'b10, 3);
    run("sz", 1'b1, 2'b10, 1);
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    run("sz_wait", 1'b0, 2'b11, 3);
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
    run("sz_tick1", 1'b0, 2'b11, 3);
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
    run("sz_re", 1'b1, 2'b10, 2);
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    run("sz_re", 1'b1, 2'b10, 1);
    run("sz_re", 1'b0, 2'b10, 3);
    run("sz_re", 1'b1, 2'b10, 4);
    run("sz_re", 1'b0, 2'b10, 3);
    run("sz_re", 1'b1, 2'b10, 4);
    chk_out("sz_end", 1'b0, 2'b00, 1'b1);
    step();

    // alarm preempts a 5-beep chime in beep 2
    chime_count = 4'd5;
    chime_req = 1'b1;
    step();
    chime_req = 1'b0;
    run("pre", 1'b1, 2'b01, 4);
    run("pre", 1'b0, 2'b01, 3);
    run("pre", 1'b1, 2'b01, 2);
    alarm_req = 1'b1;
    step();
    alarm_req = 1'b0;
    alarm_beeps("pre_al");

    // stop beats alarm_req during a chime
    chime_count = 4'd3;
    chime_req = 1'b1;
    step();
    chime_req = 1'b0;
    run("stp", 1'b1, 2'b01, 2);
    stop = 1'b1;
    alarm_req = 1'b1;
    step();
    stop = 1'b0;
    alarm_req = 1'b0;
    run("stp_idle", 1'b0, 2'b00, 6);

    // stop in snooze, snooze count cleared
    for (int r = 0; r < 2; r++) begin
      alarm_req = 1'b1;
      step();
      alarm_req = 1'b0;
      run("ss", 1'b1, 2'b10, 1);
      snooze = 1'b1;
      step();
      snooze = 1'b0;
      chk_out("ss_snz", 1'b0, 2'b11, 1'b0);
      step();
      stop = 1'b1;
      step();
      stop = 1'b0;
      run("ss_idle", 1'b0, 2'b00, 3);
    end

    // async reset mid alarm beep
    alarm_req = 1'b1;
    step();
    alarm_req = 1'b0;
    run("rs", 1'b1, 2'b10, 2);
    #2;
    rstn = 1'b0;
    #1;
    chk_out("rs_async", 1'b0, 2'b00, 1'b0);
    step();
    step();
    chk_out("rs_hold", 1'b0, 2'b00, 1'b0);
    rstn = 1'b1;
    step();
    chime_count = 4'd1;
    chime_req = 1'b1;
    step();
    chime_req = 1'b0;
    run("rs_ch1", 1'b1, 2'b01, 4);
    run("rs_end", 1'b0, 2'b00, 4);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
